// File: rtl/keypad_bcd_encoder_if.sv
// Keypad entry bus: raw key lines and controls in, BCD timer digits and event pulses out.
interface keypad_bcd_encoder_if;
   logic [9:0] keypad;
   logic       load_en;
   logic       clear;
   logic [3:0] sec_ones;
   logic [3:0] sec_tens;
   logic [3:0] mins;
   logic       new_digit;
   logic       key_rejected;

   modport master (
      output keypad, load_en, clear,
      input  sec_ones, sec_tens, mins, new_digit, key_rejected
   );

   modport slave (
      input  keypad, load_en, clear,
      output sec_ones, sec_tens, mins, new_digit, key_rejected
   );
endinterface

// File: rtl/keypad_bcd_encoder.sv
// Debounces a 10-key keypad and shifts accepted digits into {mins, sec_tens, sec_ones}.
// Optional macro KEYPAD_SECTENS_LIMIT_EN refuses commits that would push sec_tens above 5.
module keypad_bcd_encoder #(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input logic                  clk,
   input logic                  rst_n,
   keypad_bcd_encoder_if.slave  bus
);
   localparam int unsigned KEYS  = 10;
   localparam int unsigned DIG_W = 4;
   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2,
      RELEASE  = 2'd3
   } state_t;

   state_t            state, state_next;
   logic [KEYS-1:0]   sync1, sk;
   logic [KEYS-1:0]   key_q, key_next;
   logic [CNT_W-1:0]  cnt, cnt_next;
   logic              commit_c;
   logic              sk_zero_c, sk_onehot_c;
   logic [DIG_W-1:0]  key_idx_c;
   logic              accept_c, refuse_c, shift_c;
   logic [DIG_W-1:0]  ones, tens, mins_q;
   logic              new_digit_q, rejected_q;

   // Two-flop synchronizer for the asynchronous key lines
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sk    <= '0;
      end else begin
         sync1 <= bus.keypad;
         sk    <= sync1;
      end
   end

   assign sk_zero_c   = (sk == '0);
   assign sk_onehot_c = !sk_zero_c && ((sk & (sk - KEYS'(1))) == '0);

   always_comb begin
      key_idx_c = '0;
      for (int i = 0; i < KEYS; i++) begin
         if (key_q[i]) key_idx_c = DIG_W'(i);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         key_q <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         key_q <= key_next;
      end
   end

   // Commit fires on the sample after the counter has seen DEBOUNCE_CYCLES stable samples
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      key_next   = key_q;
      commit_c   = 1'b0;
      unique case (state)
         IDLE: begin
            if (sk_onehot_c) begin
               key_next   = sk;
               cnt_next   = CNT_W'(1);
               state_next = DEBOUNCE;
            end
         end
         DEBOUNCE: begin
            if (sk == key_q) begin
               if (cnt == CNT_W'(DEBOUNCE_CYCLES)) begin
                  commit_c   = 1'b1;
                  state_next = HELD;
               end else begin
                  cnt_next = cnt + CNT_W'(1);
               end
            end else if (sk_onehot_c) begin
               key_next = sk;
               cnt_next = CNT_W'(1);
            end else begin
               state_next = IDLE;
            end
         end
         HELD: begin
            if (sk_zero_c) begin
               cnt_next   = CNT_W'(1);
               state_next = RELEASE;
            end
         end
         RELEASE: begin
            if (!sk_zero_c) begin
               state_next = HELD;
            end else if (cnt >= CNT_W'(DEBOUNCE_CYCLES)) begin
               state_next = IDLE;
            end else begin
               cnt_next = cnt + CNT_W'(1);
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign accept_c = commit_c && bus.load_en;

`ifdef KEYPAD_SECTENS_LIMIT_EN
   assign refuse_c = accept_c && (ones > DIG_W'(5));
`else
   assign refuse_c = 1'b0;
`endif

   assign shift_c = accept_c && !refuse_c;

   // Digit shift register; clear wins over a same-cycle commit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ones        <= '0;
         tens        <= '0;
         mins_q      <= '0;
         new_digit_q <= 1'b0;
         rejected_q  <= 1'b0;
      end else begin
         new_digit_q <= 1'b0;
         rejected_q  <= 1'b0;
         if (bus.clear) begin
            ones   <= '0;
            tens   <= '0;
            mins_q <= '0;
         end else if (shift_c) begin
            mins_q      <= tens;
            tens        <= ones;
            ones        <= key_idx_c;
            new_digit_q <= 1'b1;
         end else if (refuse_c) begin
            rejected_q <= 1'b1;
         end
      end
   end

   assign bus.sec_ones     = ones;
   assign bus.sec_tens     = tens;
   assign bus.mins         = mins_q;
   assign bus.new_digit    = new_digit_q;
   assign bus.key_rejected = rejected_q;
endmodule
